codec_i2c_target: RTL and testbench
===================================

// Module: codec_i2c_target
// PURPOSE
//  I2C write-only target modelling the WM8731-style codec control port: decodes
//  3-byte frames {dev_addr+W, reg_addr[6:0]|data[8], data[7:0]} on the codec bus.
//  Sits on the same i2c_sclk/i2c_sdat net as the codec configuration sequencer.
//  Used as an on-chip shadow/monitor of codec settings and as the bus responder
//  in loopback builds. Exposes a register-write strobe plus decoded key fields.
// PARAMETERS
//  DEV_ADDR   7'h1A  7-bit target address (write byte 8'h34)
//  VOL_RST    7'h79  reset/soft-reset value of hp_vol_l / hp_vol_r
// PORTS
//  clk          in   1  system clock, >= 20x SCL frequency
//  rst_n        in   1  asynchronous, active-low reset
//  scl_i        in   1  I2C SCL, asynchronous
//  sda_i        in   1  I2C SDA, asynchronous
//  sda_oe       out  1  1 = drive SDA low (open-drain); 0 = release
//  reg_wr_en    out  1  one-clk pulse: a complete valid frame was received
//  reg_wr_addr  out  7  register address of last accepted frame
//  reg_wr_data  out  9  register data of last accepted frame
//  hp_vol_l     out  7  reg 0x02 data[6:0]
//  hp_vol_r     out  7  reg 0x03 data[6:0]
//  codec_active out  1  reg 0x09 data[0]
//  busy         out  1  1 between START and STOP
//  frame_err    out  1  one-clk pulse on malformed frame
// BEHAVIOUR
//  Reset: sda_oe=0, reg_wr_en=0, reg_wr_addr=0, reg_wr_data=0, hp_vol_l/r=VOL_RST,
//   codec_active=0, busy=0, frame_err=0, state IDLE. Async assert, sync deassert.
//  Input path: scl_i/sda_i each through 2-FF synchronizer + 1 history FF; all
//   events below use synced values. Event latency from pin = 3 clk.
//  START: SDA 1->0 while SCL=1. STOP: SDA 0->1 while SCL=1. Either is recognised
//   in any state; START wins over bit sampling in the same cycle.
//  Data bit sampled on SCL rising edge, MSB first, 3-bit counter per byte.
//  States: IDLE, ADDR, ACK_A, REG, ACK_R, DATA, ACK_D, IGNORE.
//   IDLE --START--> ADDR (busy=1, counter=0).
//   ADDR: after 8th bit, match {DEV_ADDR,1'b0} -> ACK_A; else (wrong addr or
//    R/W=1) -> IGNORE, no ACK.
//   ACK_x: sda_oe=1 from SCL falling edge after 8th bit to next SCL falling edge
//    (9th clock); then sda_oe=0 and go ADDR->REG, REG->DATA, DATA->IGNORE.
//   REG byte: reg_addr=byte[7:1], data[8]=byte[0]. DATA byte: data[7:0].
//   Commit: 1 clk after 8th DATA bit sampled -> reg_wr_en=1 for 1 clk, reg_wr_*
//    and decoded fields updated same cycle; ACK_D still issued.
//   IGNORE: sda_oe=0; any further byte after DATA is NACKed and pulses frame_err
//    once (at its 8th bit). Only START/STOP leave IGNORE.
//   STOP in any state -> IDLE, busy=0, sda_oe=0 same cycle.
//  Frame errors (frame_err pulse, no commit): STOP or repeated START before
//   DATA byte complete, after address ACK. Repeated START restarts ADDR phase.
//  Address NACK is not an error (no frame_err).
//  Decode on commit: addr 0x02 -> hp_vol_l=data[6:0]; 0x03 -> hp_vol_r;
//   0x09 -> codec_active=data[0]; 0x0F -> soft reset: hp_vol_l/r=VOL_RST,
//   codec_active=0. Other addrs: strobe only, no field change.
//  rst_n mid-frame: immediately release SDA, return to IDLE; bus traffic is
//   ignored until the next START.
// TESTING
//  1 Write 34 04 F9, STOP -> 3 ACKs, reg_wr_en 1 pulse, addr=0x02, data=0x0F9,
//    hp_vol_l=7'h79, frame_err=0.
//  2 Write 34 12 01 -> codec_active=1; then 34 1E 00 -> hp_vol_l/r=7'h79,
//    codec_active=0, reg_wr_addr=0x0F.
//  3 Address 36 (other target) and 35 (read) -> no ACK, sda_oe never 1, no
//    strobe, busy=1 until STOP.
//  4 34 06 then STOP -> frame_err 1 pulse, hp_vol_r unchanged.
//  5 34 06 Sr 34 06 B2 -> one frame_err at Sr, then commit hp_vol_r=7'h32.
//  6 34 0C 00 AA -> commit at 3rd byte, 4th byte NACKed with frame_err pulse;
//    rst_n pulse during ACK_R -> sda_oe=0 immediately, no commit.

Source files
------------

// File: rtl/codec_i2c_target.sv
// codec_i2c_target: write-only I2C target shadowing WM8731-style codec control registers.
//   Decodes 3-byte frames {DEV_ADDR+W, reg_addr[6:0]|data[8], data[7:0]} and publishes a write strobe
//   plus decoded headphone volume / active fields.
// Ports:
//   clk          system clock (>= 20x SCL)
//   rst_n        asynchronous active-low reset (deassertion synchronised internally)
//   scl_i/sda_i  asynchronous I2C pins
//   sda_oe       1 = pull SDA low (ACK), 0 = release
//   reg_wr_en    one-clk pulse per accepted frame; reg_wr_addr/reg_wr_data hold that frame
//   hp_vol_l/r   shadow of regs 0x02/0x03 data[6:0]; codec_active shadow of reg 0x09 data[0]
//   busy         high between START and STOP
//   frame_err    one-clk pulse on a truncated frame or an extra byte after DATA
module codec_i2c_target #(
   parameter logic [6:0] DEV_ADDR = 7'h1A,
   parameter logic [6:0] VOL_RST  = 7'h79
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe,
   output logic       reg_wr_en,
   output logic [6:0] reg_wr_addr,
   output logic [8:0] reg_wr_data,
   output logic [6:0] hp_vol_l,
   output logic [6:0] hp_vol_r,
   output logic       codec_active,
   output logic       busy,
   output logic       frame_err
);
   typedef enum logic [2:0] {IDLE, ADDR, ACK_A, REG, ACK_R, DATA, ACK_D, IGNORE} state_t;
   state_t state, stateNext;
   logic [1:0] rstSync;
   logic       rstN;
   logic [2:0] sclPipe, sdaPipe;
   logic       scl, sda, sclD, sdaD, sclRise, sclFall, startEv, stopEv;
   logic [2:0] bitCnt, cntNext;
   logic [6:0] shiftReg, shiftNext, regAddr;
   logic [7:0] byteVal;
   logic       dataHi, postData, postDataNext, sdaOeNext, busyNext;
   logic       lastBit, commit, errPulse, regLatch, inErr;

   // Reset asserts immediately but releases on a clock edge
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rstSync <= 2'b00;
      else rstSync <= {rstSync[0], 1'b1};
   assign rstN = rstSync[1];

   // [1] is the synchronised pin, [2] its previous value for edge detection
   always_ff @(posedge clk or negedge rstN)
      if (!rstN) begin
         sclPipe <= 3'b111;
         sdaPipe <= 3'b111;
      end else begin
         sclPipe <= {sclPipe[1:0], scl_i};
         sdaPipe <= {sdaPipe[1:0], sda_i};
      end

   assign scl     = sclPipe[1];
   assign sclD    = sclPipe[2];
   assign sda     = sdaPipe[1];
   assign sdaD    = sdaPipe[2];
   assign sclRise = scl & ~sclD;
   assign sclFall = ~scl & sclD;
   assign startEv = scl & sclD & sdaD & ~sda;
   assign stopEv  = scl & sclD & ~sdaD & sda;
   // Truncation is only an error once the address has been acknowledged
   assign inErr   = (state == REG) || (state == ACK_R) || (state == DATA);

   always_ff @(posedge clk or negedge rstN)
      if (!rstN) state <= IDLE;
      else state <= stateNext;

   always_comb begin
      stateNext    = state;
      sdaOeNext    = sda_oe;
      busyNext     = busy;
      cntNext      = bitCnt;
      shiftNext    = shiftReg;
      postDataNext = postData;
      commit       = 1'b0;
      errPulse     = 1'b0;
      regLatch     = 1'b0;
      byteVal      = {shiftReg, sda};
      lastBit      = sclRise && (bitCnt == 3'd7);
      if (startEv || stopEv) begin
         errPulse     = inErr;
         stateNext    = startEv ? ADDR : IDLE;
         busyNext     = startEv;
         sdaOeNext    = 1'b0;
         cntNext      = 3'd0;
         postDataNext = 1'b0;
      end else begin
         case (state)
            ADDR, REG, DATA: if (sclRise) begin
               shiftNext = byteVal[6:0];
               cntNext   = bitCnt + 3'd1;
               regLatch  = lastBit && (state == REG);
               commit    = lastBit && (state == DATA);
               if (lastBit)
                  stateNext = (state == ADDR) ? ((byteVal == {DEV_ADDR, 1'b0}) ? ACK_A : IGNORE) :
                              (state == REG)  ? ACK_R : ACK_D;
            end
            // First SCL fall after the 8th bit grabs SDA, the next one (end of 9th clock) releases it
            ACK_A, ACK_R, ACK_D: if (sclFall) begin
               sdaOeNext = ~sda_oe;
               if (sda_oe) begin
                  stateNext    = (state == ACK_A) ? REG : (state == ACK_R) ? DATA : IGNORE;
                  cntNext      = 3'd0;
                  postDataNext = (state == ACK_D);
               end
            end
            // Only the first surplus byte after DATA is flagged
            IGNORE: if (sclRise) begin
               cntNext = bitCnt + 3'd1;
               if (lastBit && postData) begin
                  errPulse     = 1'b1;
                  postDataNext = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstN)
      if (!rstN) begin
         sda_oe       <= 1'b0;
         busy         <= 1'b0;
         bitCnt       <= 3'd0;
         shiftReg     <= 7'd0;
         postData     <= 1'b0;
         regAddr      <= 7'd0;
         dataHi       <= 1'b0;
         reg_wr_en    <= 1'b0;
         frame_err    <= 1'b0;
         reg_wr_addr  <= 7'd0;
         reg_wr_data  <= 9'd0;
         hp_vol_l     <= VOL_RST;
         hp_vol_r     <= VOL_RST;
         codec_active <= 1'b0;
      end else begin
         sda_oe    <= sdaOeNext;
         busy      <= busyNext;
         bitCnt    <= cntNext;
         shiftReg  <= shiftNext;
         postData  <= postDataNext;
         reg_wr_en <= commit;
         frame_err <= errPulse;
         if (regLatch) {regAddr, dataHi} <= byteVal;
         if (commit) begin
            reg_wr_addr <= regAddr;
            reg_wr_data <= {dataHi, byteVal};
            if (regAddr == 7'h02) hp_vol_l <= byteVal[6:0];
            if (regAddr == 7'h03) hp_vol_r <= byteVal[6:0];
            if (regAddr == 7'h09) codec_active <= byteVal[0];
            if (regAddr == 7'h0F) begin
               hp_vol_l     <= VOL_RST;
               hp_vol_r     <= VOL_RST;
               codec_active <= 1'b0;
            end
         end
      end
endmodule

// File: tb/tb_codec_i2c_target.sv
// tb_codec_i2c_target: directed I2C master exercising codec_i2c_target frames, errors and reset.
module tb_codec_i2c_target;
   logic       clk = 1'b0, rst_n = 1'b0, sclPin = 1'b1, sdaPin = 1'b1;
   logic       sda_oe, reg_wr_en, codec_active, busy, frame_err, sdaBus, a;
   logic [6:0] reg_wr_addr, hp_vol_l, hp_vol_r;
   logic [8:0] reg_wr_data;
   int         errors = 0, checks = 0, wrCnt = 0, errCnt = 0, oeCnt = 0;
   int         wr0, err0, oe0;

   always #5 clk = ~clk;
   assign sdaBus = sdaPin & ~sda_oe;

   codec_i2c_target dut (
      .clk(clk), .rst_n(rst_n), .scl_i(sclPin), .sda_i(sdaBus), .sda_oe(sda_oe),
      .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
      .hp_vol_l(hp_vol_l), .hp_vol_r(hp_vol_r), .codec_active(codec_active),
      .busy(busy), .frame_err(frame_err)
   );

   // Pulse-cycle counters: a stretched pulse shows up as a count above one
   always @(negedge clk) begin
      if (reg_wr_en) wrCnt <= wrCnt + 1;
      if (frame_err) errCnt <= errCnt + 1;
      if (sda_oe) oeCnt <= oeCnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic q();
      repeat (10) @(posedge clk);
      #1;
   endtask

   task automatic startC();
      sdaPin = 1'b1; q(); sclPin = 1'b1; q(); sdaPin = 1'b0; q(); sclPin = 1'b0; q();
   endtask

   task automatic stopC();
      sdaPin = 1'b0; q(); sclPin = 1'b1; q(); sdaPin = 1'b1; q();
   endtask

   task automatic sendBits(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         sdaPin = b[i]; q(); sclPin = 1'b1; q(); sclPin = 1'b0; q();
      end
   endtask

   task automatic getAck(output logic ack);
      sdaPin = 1'b1; q(); sclPin = 1'b1; q();
      ack = (sdaBus === 1'b0);
      sclPin = 1'b0; q();
   endtask

   task automatic sendByte(input logic [7:0] b, output logic ack);
      sendBits(b);
      getAck(ack);
   endtask

   task automatic frame3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      logic k;
      startC();
      sendByte(b0, k); chk("ack_addr", k, 1);
      sendByte(b1, k); chk("ack_reg", k, 1);
      sendByte(b2, k); chk("ack_data", k, 1);
      stopC();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sda_oe", sda_oe, 0);
      chk("rst_wr_en", reg_wr_en, 0);
      chk("rst_addr", reg_wr_addr, 0);
      chk("rst_data", reg_wr_data, 0);
      chk("rst_vol_l", hp_vol_l, 7'h79);
      chk("rst_vol_r", hp_vol_r, 7'h79);
      chk("rst_active", codec_active, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ferr", frame_err, 0);
      rst_n = 1'b1;
      q();

      // Write reg 0x02 = 0x0F9
      frame3(8'h34, 8'h04, 8'hF9);
      chk("t1_wr_cnt", wrCnt, 1);
      chk("t1_addr", reg_wr_addr, 7'h02);
      chk("t1_data", reg_wr_data, 9'h0F9);
      chk("t1_vol_l", hp_vol_l, 7'h79);
      chk("t1_ferr", errCnt, 0);
      chk("t1_busy", busy, 0);

      frame3(8'h34, 8'h04, 8'h25);
      chk("t1b_vol_l", hp_vol_l, 7'h25);
      frame3(8'h34, 8'h07, 8'h40);
      chk("t1c_vol_r", hp_vol_r, 7'h40);
      chk("t1c_data", reg_wr_data, 9'h140);

      // Activate, then soft reset through reg 0x0F
      frame3(8'h34, 8'h12, 8'h01);
      chk("t2_active", codec_active, 1);
      chk("t2_addr", reg_wr_addr, 7'h09);
      frame3(8'h34, 8'h1E, 8'h00);
      chk("t2_vol_l", hp_vol_l, 7'h79);
      chk("t2_vol_r", hp_vol_r, 7'h79);
      chk("t2_active", codec_active, 0);
      chk("t2_addr_f", reg_wr_addr, 7'h0F);
      chk("t2_wr_cnt", wrCnt, 5);

      // Foreign address and read request are not acknowledged
      wr0 = wrCnt; err0 = errCnt; oe0 = oeCnt;
      startC();
      sendByte(8'h36, a); chk("t3_ack36", a, 0);
      chk("t3_busy36", busy, 1);
      sendByte(8'h04, a); chk("t3_ack36b", a, 0);
      stopC();
      chk("t3_busy_off", busy, 0);
      startC();
      sendByte(8'h35, a); chk("t3_ack35", a, 0);
      chk("t3_busy35", busy, 1);
      stopC();
      chk("t3_oe", oeCnt - oe0, 0);
      chk("t3_wr", wrCnt - wr0, 0);
      chk("t3_ferr", errCnt - err0, 0);

      // STOP before the DATA byte
      wr0 = wrCnt; err0 = errCnt;
      startC();
      sendByte(8'h34, a);
      sendByte(8'h06, a); chk("t4_ack_reg", a, 1);
      stopC();
      chk("t4_ferr", errCnt - err0, 1);
      chk("t4_wr", wrCnt - wr0, 0);
      chk("t4_vol_r", hp_vol_r, 7'h79);

      // Repeated START mid-frame, then a complete frame
      wr0 = wrCnt; err0 = errCnt;
      startC();
      sendByte(8'h34, a);
      sendByte(8'h06, a);
      startC();
      chk("t5_ferr_sr", errCnt - err0, 1);
      sendByte(8'h34, a); chk("t5_ack_a", a, 1);
      sendByte(8'h06, a); chk("t5_ack_r", a, 1);
      sendByte(8'hB2, a); chk("t5_ack_d", a, 1);
      stopC();
      chk("t5_ferr", errCnt - err0, 1);
      chk("t5_wr", wrCnt - wr0, 1);
      chk("t5_vol_r", hp_vol_r, 7'h32);
      chk("t5_data", reg_wr_data, 9'h0B2);

      // Surplus fourth byte
      wr0 = wrCnt; err0 = errCnt;
      startC();
      sendByte(8'h34, a);
      sendByte(8'h0C, a);
      sendByte(8'h00, a); chk("t6_ack_d", a, 1);
      chk("t6_wr", wrCnt - wr0, 1);
      chk("t6_addr", reg_wr_addr, 7'h06);
      sendByte(8'hAA, a); chk("t6_nack4", a, 0);
      chk("t6_ferr", errCnt - err0, 1);
      stopC();
      chk("t6_ferr_stop", errCnt - err0, 1);

      // Reset pulse while the target holds the REG ACK
      wr0 = wrCnt;
      startC();
      sendByte(8'h34, a);
      sendBits(8'h0C);
      sdaPin = 1'b1; q(); sclPin = 1'b1; q();
      chk("t6r_oe_on", sda_oe, 1);
      rst_n = 1'b0;
      #1;
      chk("t6r_oe_off", sda_oe, 0);
      chk("t6r_busy", busy, 0);
      sclPin = 1'b0; q();
      rst_n = 1'b1;
      q();
      oe0 = oeCnt;
      sendByte(8'hAA, a); chk("t6r_ign_ack", a, 0);
      sendByte(8'h00, a);
      chk("t6r_busy_ign", busy, 0);
      stopC();
      chk("t6r_wr", wrCnt - wr0, 0);
      chk("t6r_oe", oeCnt - oe0, 0);
      chk("t6r_addr", reg_wr_addr, 0);
      chk("t6r_vol_l", hp_vol_l, 7'h79);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
